// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: serialises fetch and data requests onto one fixed-latency
// memory port with round-robin arbitration, stall generation and halt quiescing.
module mem_port_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              halted,
  output logic              err
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_BUSY_IF = 2'd1;
  localparam logic [1:0] c_ST_BUSY_DM = 2'd2;
  localparam logic [3:0] c_CNT_LOAD   = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_last;
  logic              r_halt_pend;
  logic              r_halted;
  logic              r_err;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_idle;
  logic              w_block;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic              w_grant;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_if_done;
  logic              w_dm_done;
  logic              w_dm_load_done;

  assign w_idle  = (r_state == c_ST_IDLE);
  // A pending or live halt, or an already-quiesced port, suppresses every grant.
  assign w_block = halt | r_halt_pend | r_halted;

  // Data wins a tie unless it was granted last.
  assign w_grant_dm   = w_idle & ~w_block & dm_req & (~if_req | ~r_last);
  assign w_grant_if   = w_idle & ~w_block & if_req & ~w_grant_dm;
  assign w_grant      = w_grant_dm | w_grant_if;
  assign w_grant_addr = w_grant_dm ? dm_addr : if_addr;

  assign w_if_done      = (r_state == c_ST_BUSY_IF) & (r_cnt == 4'd0);
  assign w_dm_done      = (r_state == c_ST_BUSY_DM) & (r_cnt == 4'd0);
  assign w_dm_load_done = w_dm_done & ~r_mem_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= w_grant;
      r_halt_pend <= r_halt_pend | halt;
      if (w_grant && w_grant_addr[0]) begin
        r_err <= 1'b1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (w_grant_dm) begin
            r_state     <= c_ST_BUSY_DM;
            r_mem_addr  <= dm_addr;
            r_mem_wr    <= dm_wr;
            r_mem_wdata <= dm_wdata;
            r_cnt       <= c_CNT_LOAD;
            r_last      <= 1'b1;
          end else if (w_grant_if) begin
            r_state    <= c_ST_BUSY_IF;
            r_mem_addr <= if_addr;
            r_mem_wr   <= 1'b0;
            r_cnt      <= c_CNT_LOAD;
            r_last     <= 1'b0;
          end else if (halt || r_halt_pend) begin
            r_halted <= 1'b1;
          end
        end
        c_ST_BUSY_IF, c_ST_BUSY_DM: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_if_done) begin
        r_if_rdata <= mem_rdata;
      end
      if (w_dm_load_done) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  // Read data is forwarded in the completion cycle, then held from the register.
  assign if_rdata  = w_if_done ? mem_rdata : r_if_rdata;
  assign dm_rdata  = w_dm_load_done ? mem_rdata : r_dm_rdata;
  assign if_done   = w_if_done;
  assign dm_done   = w_dm_done;
  assign if_stall  = if_req & ~w_if_done;
  assign dm_stall  = dm_req & ~w_dm_done;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = r_halted;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: randomized requesters and a memory model; a transaction
// level reference predicts issues and completions into scoreboard queues.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_stall, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_wr, dm_stall, dm_done;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              halt, halted, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halt(halt), .halted(halted), .err(err)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    bit          is_dm;
  } issue_t;

  typedef struct {
    int          cyc;
    bit          is_dm;
    bit          rd;
    logic [15:0] rdata;
  } done_t;

  issue_t issue_q[$];
  done_t  done_q[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [15:0] bus_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  int          mem_cd = -1;
  logic [15:0] mem_a = '0;

  int          m_free_at;
  bit          m_last, m_hp, m_halted, m_err;
  logic [15:0] m_if_q, m_dm_q;
  bit          if_done_seen, dm_done_seen, dm_load_issued;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hA5A5;
  endfunction

  function logic [15:0] bus_rd(input logic [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  function logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 63)) << 1;
    if ($urandom_range(0, 19) == 0) a[0] = 1'b1;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Memory macro: latches the address at issue, write takes effect at issue,
  // read data is valid only MEM_LAT-1 cycles after the issue cycle.
  always @(negedge clk) begin
    if (!rst) begin
      mem_cd    = -1;
      mem_rdata = 16'($urandom);
    end else begin
      if (mem_en) begin
        mem_a  = mem_addr;
        mem_cd = MEM_LAT - 1;
        if (mem_wr) bus_mem[mem_addr] = mem_wdata;
      end else if (mem_cd >= 0) begin
        mem_cd--;
      end
      mem_rdata = (mem_cd == 0) ? bus_rd(mem_a) : 16'($urandom);
    end
  end

  // Monitor: compares DUT outputs with the front of the scoreboard queues.
  bit     e_if, e_dm;
  done_t  d_pop;
  issue_t i_pop;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        fail_now("missed_done");
        void'(done_q.pop_front());
      end
      e_if = 1'b0;
      e_dm = 1'b0;
      if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
        e_if = !done_q[0].is_dm;
        e_dm = done_q[0].is_dm;
      end
      chk("if_done", if_done, e_if);
      chk("dm_done", dm_done, e_dm);
      chk("if_stall", if_stall, if_req & ~e_if);
      chk("dm_stall", dm_stall, dm_req & ~e_dm);
      if (e_if || e_dm) begin
        d_pop = done_q.pop_front();
        if (d_pop.rd) begin
          if (d_pop.is_dm) m_dm_q = d_pop.rdata;
          else             m_if_q = d_pop.rdata;
        end
      end
      chk("if_rdata", if_rdata, m_if_q);
      chk("dm_rdata", dm_rdata, m_dm_q);
      chk("halted", halted, m_halted);
      chk("err", err, m_err);
      if (issue_q.size() > 0 && issue_q[0].cyc < cyc) begin
        fail_now("missed_issue");
        void'(issue_q.pop_front());
      end
      if (mem_en) begin
        if (issue_q.size() == 0) begin
          fail_now("unexpected_mem_en");
        end else begin
          i_pop = issue_q.pop_front();
          chk("issue_cycle", cyc, i_pop.cyc);
          chk("mem_addr", mem_addr, i_pop.addr);
          chk("mem_wr", mem_wr, i_pop.wr);
          if (i_pop.wr) chk("mem_wdata", mem_wdata, i_pop.wdata);
          if (i_pop.is_dm && !i_pop.wr) dm_load_issued = 1'b1;
        end
      end
      if_done_seen = if_done;
      dm_done_seen = dm_done;
    end
  end

  // Reference: one transaction at a time, next grant no earlier than
  // grant+MEM_LAT+1, ties alternate starting with data after reset.
  bit          pick_dm;
  logic [15:0] g_addr;
  issue_t      i_new;
  done_t       d_new;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (cyc >= m_free_at && !m_halted) begin
        if (halt || m_hp) begin
          m_halted = 1'b1;
        end else if (dm_req || if_req) begin
          pick_dm     = dm_req && (!if_req || !m_last);
          g_addr      = pick_dm ? dm_addr : if_addr;
          i_new.cyc   = cyc + 1;
          i_new.addr  = g_addr;
          i_new.wr    = pick_dm ? dm_wr : 1'b0;
          i_new.wdata = dm_wdata;
          i_new.is_dm = pick_dm;
          issue_q.push_back(i_new);
          d_new.cyc   = cyc + MEM_LAT;
          d_new.is_dm = pick_dm;
          d_new.rd    = !i_new.wr;
          d_new.rdata = ref_rd(g_addr);
          if (i_new.wr) ref_mem[g_addr] = dm_wdata;
          done_q.push_back(d_new);
          m_free_at = cyc + MEM_LAT + 1;
          m_last    = pick_dm;
          if (g_addr[0]) m_err = 1'b1;
        end
      end
      if (halt) m_hp = 1'b1;
    end
  end

  task automatic model_clear();
    issue_q.delete();
    done_q.delete();
    m_free_at = 0;
    m_last = 0; m_hp = 0; m_halted = 0; m_err = 0;
    m_if_q = '0; m_dm_q = '0;
    if_done_seen = 0; dm_done_seen = 0; dm_load_issued = 0;
  endtask

  // p_new: percent chance an idle requester raises a request; p_keep: percent
  // chance a requester keeps req high after done (a new back-to-back request).
  task automatic drive_cycle(input int p_new, input int p_keep);
    if (if_req) begin
      if (if_done_seen) begin
        if ($urandom_range(0, 99) < p_keep) if_addr = rand_addr();
        else if_req = 1'b0;
      end
    end else if ($urandom_range(0, 99) < p_new) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
    if (dm_req) begin
      if (dm_done_seen) begin
        if ($urandom_range(0, 99) < p_keep) begin
          dm_addr  = rand_addr();
          dm_wr    = 1'($urandom_range(0, 1));
          dm_wdata = 16'($urandom);
        end else begin
          dm_req = 1'b0;
        end
      end
    end else if ($urandom_range(0, 99) < p_new) begin
      dm_req   = 1'b1;
      dm_addr  = rand_addr();
      dm_wr    = 1'($urandom_range(0, 1));
      dm_wdata = 16'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_done"}, if_done, 0);
    chk({tag, "_dm_done"}, dm_done, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic quiet_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    halt = 0;
  endtask

  initial begin
    rst = 1'b0;
    quiet_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Lone fetch of a known word.
    bus_mem[16'h0010] = 16'hA5A5;
    ref_mem[16'h0010] = 16'hA5A5;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    repeat (12) begin
      @(posedge clk); #1;
      drive_cycle(0, 0);
    end

    // Sustained dual requests, then mixed random traffic.
    repeat (120) begin
      @(posedge clk); #1;
      drive_cycle(100, 100);
    end
    repeat (800) begin
      @(posedge clk); #1;
      drive_cycle(35, 40);
    end

    // Abort a data load in its second busy cycle.
    dm_load_issued = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      drive_cycle(40, 50);
      if (dm_load_issued) break;
    end
    if (!dm_load_issued) begin
      fail_now("wait_dm_load_timeout");
    end else begin
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
    end
    rst = 1'b0;
    quiet_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    repeat (12) begin
      @(posedge clk); #1;
      drive_cycle(0, 0);
    end
    repeat (400) begin
      @(posedge clk); #1;
      drive_cycle(40, 50);
    end

    // Halt with requests still arriving.
    halt = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      drive_cycle(50, 100);
    end
    @(negedge clk); #3;
    chk("halted_final", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
